pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline boundary register for the pipelined ARM core. Replaces the fixed per-stage registers (e.g. EX->MEM) with one reusable block.
- Carries an opaque payload: control bits packed with data by the instantiating stage.
- Adds a valid/ready handshake, hazard-unit stall and flush (bubble insertion), an optional skid buffer to register the ready path, and a saturating backpressure counter for performance debug.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/sat_counter.sv | 37 +++
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: per-boundary payload structs and the
// widths the stage registers are sized from.
package pipe_pkg;

    typedef struct packed {
        logic        pcsrc;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic [3:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] write_data;
    } mem_stage_t;

    localparam int MEM_STAGE_W = $bits(mem_stage_t);
    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CNT_W  = 16;

    function automatic logic sat_full(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return v == max_v;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear taking priority
// over the increment.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = PIPE_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline boundary register: valid/ready handshake, hazard
// stall/flush, optional skid entry and a backpressure cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = PIPE_DATA_W,
    parameter bit SKID           = 1'b0,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bp_count,
    input  logic              bp_clear
);

    logic              valid_q, valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;
    logic              main_free;

    // Ready is gated by reset so nothing is accepted while held in reset.
    if (SKID) begin : g_skid_rdy
        assign in_ready = ~reset & ~stall & ~skid_valid_q;
    end else begin : g_comb_rdy
        assign in_ready = ~reset & ~stall & (~valid_q | out_ready);
    end

    assign out_valid = valid_q & ~stall;
    assign out_data  = data_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign main_free = ~valid_q | out_fire;

    always_comb begin
        valid_d      = valid_q;
        skid_valid_d = skid_valid_q;
        data_d       = data_q;
        skid_d       = skid_q;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                data_d = '0;
                skid_d = '0;
            end
        end else if (stall) begin
            valid_d = valid_q;
        end else if (main_free) begin
            if (SKID && skid_valid_q) begin
                data_d       = skid_q;
                valid_d      = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                valid_d = in_fire;
                if (in_fire) begin
                    data_d = in_data;
                end
            end
        end else if (SKID && in_fire) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            data_q       <= '0;
            skid_q       <= '0;
        end else begin
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
            data_q       <= data_d;
            skid_q       <= skid_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_bp_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (out_valid & ~out_ready),
        .clr  (bp_clear),
        .count(bp_count)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed checks of pipe_stage_reg in skid and single-register builds.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush, stall, in_valid, out_ready, bp_clear;
    logic        in_ready, out_valid;
    logic [15:0] in_data, out_data;
    logic [3:0]  bp_count;

    logic        flush0, stall0, in_valid0, out_ready0, bp_clear0;
    logic        in_ready0, out_valid0;
    logic [7:0]  in_data0, out_data0, bp_count0;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg #(
        .DATA_W(16), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bp_count(bp_count), .bp_clear(bp_clear)
    );

    pipe_stage_reg #(
        .DATA_W(8), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b0), .CNT_W(8)
    ) dut0 (
        .clk(clk), .reset(reset), .flush(flush0), .stall(stall0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .bp_count(bp_count0), .bp_clear(bp_clear0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 0; stall = 0; in_valid = 0; out_ready = 0; bp_clear = 0;
        in_data = '0;
        flush0 = 0; stall0 = 0; in_valid0 = 0; out_ready0 = 0;
        bp_clear0 = 0; in_data0 = '0;

        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_bp", 32'(bp_count), 32'd0);
        #11 reset = 1'b0;
        step();
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // reset while an entry is held
        in_valid = 1; in_data = 16'hDEAD; out_ready = 0;
        step();
        in_valid = 0;
        check("dead_loaded", 32'(out_data), 32'hDEAD);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        #2 reset = 1'b0;
        step();
        check("rerst_ready", 32'(in_ready), 32'd1);
        check("rerst_valid", 32'(out_valid), 32'd0);

        // streaming
        out_ready = 1; in_valid = 1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 16'(i);
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", 32'(out_data), 32'(i));
        end
        in_valid = 0;
        step();
        check("stream_end", 32'(out_valid), 32'd0);
        check("stream_bp", 32'(bp_count), 32'd0);

        // backpressure through the skid entry
        out_ready = 0; in_valid = 1; in_data = 16'hA;
        step();
        check("bp_a_main", 32'(out_data), 32'hA);
        check("bp_ready_a", 32'(in_ready), 32'd1);
        in_data = 16'hB;
        step();
        check("bp_full", 32'(in_ready), 32'd0);
        in_data = 16'hC;
        step();
        check("bp_hold_c", 32'(in_ready), 32'd0);
        check("bp_hold_a", 32'(out_data), 32'hA);
        step();
        check("bp_count3", 32'(bp_count), 32'd3);
        out_ready = 1;
        check("bp_out_a", 32'(out_data), 32'hA);
        step();
        check("bp_out_b", 32'(out_data), 32'hB);
        check("bp_ready_b", 32'(in_ready), 32'd1);
        step();
        in_valid = 0;
        check("bp_out_c", 32'(out_data), 32'hC);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_final", 32'(bp_count), 32'd3);
        bp_clear = 1;
        step();
        bp_clear = 0;
        check("bp_cleared", 32'(bp_count), 32'd0);

        // stall holds everything
        out_ready = 0; in_valid = 1; in_data = 16'h55;
        step();
        in_valid = 0; stall = 1;
        #1;
        check("stall_valid", 32'(out_valid), 32'd0);
        check("stall_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_data", 32'(out_data), 32'h55);
            check("stall_oval", 32'(out_valid), 32'd0);
        end
        check("stall_bp", 32'(bp_count), 32'd0);
        stall = 0; out_ready = 1;
        #1;
        check("unstall_valid", 32'(out_valid), 32'd1);
        check("unstall_data", 32'(out_data), 32'h55);
        step();
        check("stall_once", 32'(out_valid), 32'd0);

        // flush beats a coincident accept
        in_valid = 1; in_data = 16'h77; flush = 1;
        step();
        flush = 0; in_valid = 0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_data", 32'(out_data), 32'd0);
        step();
        check("flush_no77", 32'(out_valid), 32'd0);

        // counter saturation and clear priority
        out_ready = 0; in_valid = 1; in_data = 16'h9;
        step();
        in_valid = 0;
        repeat (20) step();
        check("sat_15", 32'(bp_count), 32'd15);
        bp_clear = 1;
        step();
        bp_clear = 0;
        check("sat_clr", 32'(bp_count), 32'd0);
        step();
        check("sat_resume", 32'(bp_count), 32'd1);

        // single-register build: combinational ready, hold-on-flush
        out_ready0 = 0; in_valid0 = 1; in_data0 = 8'h11;
        step();
        in_valid0 = 0;
        check("s0_data", 32'(out_data0), 32'h11);
        check("s0_busy", 32'(in_ready0), 32'd0);
        out_ready0 = 1;
        #1;
        check("s0_comb_rdy", 32'(in_ready0), 32'd1);
        in_valid0 = 1; in_data0 = 8'h22;
        step();
        check("s0_replace", 32'(out_data0), 32'h22);
        check("s0_nobubble", 32'(out_valid0), 32'd1);
        flush0 = 1; in_data0 = 8'h33;
        step();
        flush0 = 0; in_valid0 = 0;
        check("s0_flush_v", 32'(out_valid0), 32'd0);
        check("s0_flush_hold", 32'(out_data0), 32'h22);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
